// File: rtl/uart_tx_sequencer.sv
// Transmit-side sequencer of the APB UART: pops bytes from the TX FIFO and serialises them
// as start, LSB-first data, optional parity and one or two stop bits at a programmable bit period.
module uart_tx_sequencer #(
    parameter int DIV_WIDTH  = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  clk_en_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    input  logic                  parity_en_i,
    input  logic                  parity_type_i,
    input  logic                  extra_stop_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_valid_i,
    output logic                  fifo_pop_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_e;

    state_e                state_q;
    logic [DIV_WIDTH-1:0]  cnt_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  tx_q;

    logic bit_end;
    logic last_stop;
    logic pop;

    // The counter is compared against the latched divider, so a CLK_DIV write mid-frame
    // can never leave the counter beyond its terminal value.
    assign bit_end   = (cnt_q == div_q);
    assign last_stop = bit_end && (((state_q == STOP1) && !stop2_q) || (state_q == STOP2));
    assign pop       = !arst_i && clk_en_i && fifo_valid_i && ((state_q == IDLE) || last_stop);

    assign fifo_pop_o   = pop;
    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = last_stop;

    // NOTE: every register here updates with <= so all of them see pre-edge values; the async
    // reset branch must assign every register or synthesis infers a mux on the reset path.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else if (pop) begin
            state_q   <= START;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= fifo_data_i;
            div_q     <= clk_div_i;
            par_en_q  <= parity_en_i;
            par_bit_q <= (^fifo_data_i) ^ parity_type_i;
            stop2_q   <= extra_stop_i;
            tx_q      <= 1'b0;
        end else if (state_q == IDLE) begin
            tx_q <= 1'b1;
        end else if (!bit_end) begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
        end else begin
            cnt_q <= '0;
            case (state_q)
                START: begin
                    state_q <= DATA;
                    tx_q    <= data_q[0];
                end
                DATA: begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_q <= par_en_q ? PARITY : STOP1;
                        tx_q    <= par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        // Shift register keeps the next bit at index 1, so no variable index is needed.
                        idx_q  <= idx_q + IDX_W'(1);
                        data_q <= data_q >> 1;
                        tx_q   <= data_q[1];
                    end
                end
                PARITY: begin
                    state_q <= STOP1;
                    tx_q    <= 1'b1;
                end
                STOP1: begin
                    state_q <= stop2_q ? STOP2 : IDLE;
                    tx_q    <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
